// File: rtl/operand_stream_ctrl.sv
// BRAM-to-adder operand sequencer: walks a dual-operand BRAM and streams {A,B}
// pairs (optionally as A + ~B + 1) with valid/last tags and run status.
module operand_stream_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_stop,
    input  logic                add_sub,
    input  logic                one_shot,
    input  logic [2*DATA_W-1:0] douta,
    output logic                ena,
    output logic [ADDR_W-1:0]   addra,
    output logic [DATA_W-1:0]   op_a,
    output logic [DATA_W-1:0]   op_b,
    output logic                cin,
    output logic                op_valid,
    output logic                op_last,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ena;
    logic [ADDR_W-1:0]   r_addra;
    logic                r_busy;
    logic                r_done;
    logic                r_sub;
    logic                r_one_shot;
    logic [RD_LAT-1:0]   r_vld_sr;
    logic [RD_LAT-1:0]   r_last_sr;
    logic                r_op_valid;
    logic                r_op_last;
    logic [DATA_W-1:0]   r_op_a;
    logic [DATA_W-1:0]   r_op_b;
    logic                r_cin;

    logic [ADDR_W-1:0]   w_addra_nxt;
    logic                w_abort;
    logic                w_latch_cfg;
    logic                w_cap;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_addra_nxt = r_addra;
        w_abort     = 1'b0;
        w_latch_cfg = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_addra_nxt = '0;
                if (start_stop) begin
                    w_state_nxt = S_RUN;
                    w_latch_cfg = 1'b1;
                end
            end
            S_RUN: begin
                if (!start_stop) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_addra_nxt = '0;
                end else if (r_addra == LAST_ADDR) begin
                    if (r_one_shot) begin
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_addra_nxt = '0;
                    end
                end else begin
                    w_addra_nxt = r_addra + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (!start_stop) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_addra_nxt = '0;
                end else if (r_op_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!start_stop) begin
                    w_state_nxt = S_IDLE;
                    w_addra_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_addra_nxt = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Control outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ena      <= 1'b0;
            r_addra    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_sub      <= 1'b0;
            r_one_shot <= 1'b0;
        end else begin
            r_ena   <= (w_state_nxt == S_RUN);
            r_addra <= w_addra_nxt;
            r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done  <= (w_state_nxt == S_DONE);
            if (w_latch_cfg) begin
                r_sub      <= add_sub;
                r_one_shot <= one_shot;
            end
        end
    end

    assign w_cap = r_vld_sr[RD_LAT-1] && !w_abort;

    // Tags travel RD_LAT stages to meet douta, then one more into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_sr   <= '0;
            r_last_sr  <= '0;
            r_op_valid <= 1'b0;
            r_op_last  <= 1'b0;
        end else if (w_abort) begin
            r_vld_sr   <= '0;
            r_last_sr  <= '0;
            r_op_valid <= 1'b0;
            r_op_last  <= 1'b0;
        end else begin
            r_vld_sr[0]  <= r_ena;
            r_last_sr[0] <= r_ena && (r_addra == LAST_ADDR);
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_sr[i]  <= r_vld_sr[i-1];
                r_last_sr[i] <= r_last_sr[i-1];
            end
            r_op_valid <= r_vld_sr[RD_LAT-1];
            r_op_last  <= r_vld_sr[RD_LAT-1] && r_last_sr[RD_LAT-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a <= '0;
            r_op_b <= '0;
            r_cin  <= 1'b0;
        end else if (w_cap) begin
            r_op_a <= douta[2*DATA_W-1:DATA_W];
            r_op_b <= r_sub ? ~douta[DATA_W-1:0] : douta[DATA_W-1:0];
            r_cin  <= r_sub;
        end
    end

    assign ena      = r_ena;
    assign addra    = r_addra;
    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign cin      = r_cin;
    assign op_valid = r_op_valid;
    assign op_last  = r_op_last;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
